// File: rtl/uart_io_ctl.sv
// UART request responder: serialises 1/2/4-byte OUT words onto a byte transmitter and
// gathers received bytes, buffered in an RX FIFO, into little-endian IN words.
module uart_io_ctl #(
  parameter int RX_DEPTH_LOG2 = 9
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        uart_wenable,
  input  logic [1:0]  uart_wsz,
  input  logic [31:0] uart_wd,
  output logic        uart_wdone,
  input  logic        uart_renable,
  input  logic [1:0]  uart_rsz,
  output logic [31:0] uart_rd,
  output logic        uart_rdone,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_overrun
);

  localparam int DEPTH = 1 << RX_DEPTH_LOG2;

  typedef enum logic { T_IDLE, T_SEND } tx_state_t;
  typedef enum logic { R_IDLE, R_GATHER } rx_state_t;

  // Index of the last byte of a transfer: 1, 2 or 4 bytes.
  function automatic logic [1:0] size_last(input logic [1:0] sz);
    logic [1:0] last;
    case (sz)
      2'b00:   last = 2'd0;
      2'b01:   last = 2'd1;
      default: last = 2'd3;
    endcase
    return last;
  endfunction

  // ---------------- TX path ----------------
  tx_state_t   tx_state, tx_state_nxt;
  logic [31:0] tx_word;
  logic [1:0]  tx_last;
  logic [1:0]  tx_k;
  logic        tx_fire;
  logic        tx_final;

  assign tx_valid = (tx_state == T_SEND);
  // Gated so tx_data reads zero whenever nothing is offered, including in reset.
  assign tx_data  = tx_valid ? tx_word[{tx_k, 3'b000} +: 8] : 8'h00;
  assign tx_fire  = tx_valid && tx_ready;
  assign tx_final = tx_fire && (tx_k == tx_last);

  always_comb begin
    tx_state_nxt = tx_state;
    case (tx_state)
      T_IDLE:  if (uart_wenable) tx_state_nxt = T_SEND;
      T_SEND:  if (tx_final) tx_state_nxt = T_IDLE;
      default: tx_state_nxt = T_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tx_state    <= T_IDLE;
      tx_last     <= 2'd0;
      tx_k        <= 2'd0;
      uart_wdone  <= 1'b0;
    end else begin
      tx_state   <= tx_state_nxt;
      uart_wdone <= tx_final;
      if (tx_state == T_IDLE && uart_wenable) begin
        tx_last <= size_last(uart_wsz);
        tx_k    <= 2'd0;
      end else if (tx_fire) begin
        tx_k    <= tx_k + 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (tx_state == T_IDLE && uart_wenable) tx_word <= uart_wd;
  end

  // ---------------- RX FIFO ----------------
  logic [7:0]               rx_mem [DEPTH];
  logic [RX_DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [RX_DEPTH_LOG2:0]   fifo_cnt;
  logic                     fifo_full, fifo_empty;
  logic                     push, pop;
  logic [7:0]               rx_byte;

  // The count never exceeds DEPTH, so its top bit alone marks full.
  assign fifo_full  = fifo_cnt[RX_DEPTH_LOG2];
  assign fifo_empty = (fifo_cnt == '0);
  assign push       = rx_valid && !fifo_full;
  assign rx_byte    = rx_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) rx_mem[wr_ptr] <= rx_data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_cnt   <= '0;
      rx_overrun <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
      if (rx_valid && fifo_full) rx_overrun <= 1'b1;
    end
  end

  // ---------------- RX gather ----------------
  rx_state_t   rx_state, rx_state_nxt;
  logic [1:0]  rx_last;
  logic [1:0]  rx_k;
  logic [31:0] rx_acc;
  logic [31:0] rx_word_nxt;
  logic        rx_final;

  assign pop         = (rx_state == R_GATHER) && !fifo_empty;
  assign rx_word_nxt = rx_acc | ({24'h000000, rx_byte} << {rx_k, 3'b000});
  assign rx_final    = pop && (rx_k == rx_last);

  always_comb begin
    rx_state_nxt = rx_state;
    case (rx_state)
      R_IDLE:   if (uart_renable) rx_state_nxt = R_GATHER;
      R_GATHER: if (rx_final) rx_state_nxt = R_IDLE;
      default:  rx_state_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_state   <= R_IDLE;
      rx_last    <= 2'd0;
      rx_k       <= 2'd0;
      uart_rd    <= 32'h0;
      uart_rdone <= 1'b0;
    end else begin
      rx_state   <= rx_state_nxt;
      uart_rdone <= rx_final;
      if (rx_final) uart_rd <= rx_word_nxt;
      if (rx_state == R_IDLE && uart_renable) begin
        rx_last <= size_last(uart_rsz);
        rx_k    <= 2'd0;
      end else if (pop) begin
        rx_k    <= rx_k + 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rx_state == R_IDLE && uart_renable) rx_acc <= 32'h0;
    else if (pop)                           rx_acc <= rx_word_nxt;
  end

endmodule
